// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the MEM_main data port: the CPU and the loader share one
// registered memory interface, and each access runs IDLE -> ACCESS -> DONE.
module mem_port_arbiter #(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_ack,
  output logic        ld_err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        Mem_WrEn,
  output logic [31:0] ALU_MEM_Addr,
  output logic [31:0] MEM_DataIn,
  input  logic [31:0] MEM_DataOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic        last_grant;   // 0 = cpu, 1 = ld
  logic        gnt_id;
  logic        gnt_we;
  logic        gnt_in_range;
  logic        grant;
  logic        pick_ld;
  logic        sel_we;
  logic        sel_in_range;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On conflict the port that did not win last time is granted.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    pick_ld   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req || ld_req) begin
          grant     = 1'b1;
          pick_ld   = ld_req && (!cpu_req || !last_grant);
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_we       = pick_ld ? ld_we    : cpu_we;
  assign sel_addr     = pick_ld ? ld_addr  : cpu_addr;
  assign sel_wdata    = pick_ld ? ld_wdata : cpu_wdata;
  assign sel_in_range = (sel_addr[31:AW] == '0);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= 1'b1;
      gnt_id       <= 1'b0;
      gnt_we       <= 1'b0;
      gnt_in_range <= 1'b0;
      Mem_WrEn     <= 1'b0;
      ALU_MEM_Addr <= '0;
      MEM_DataIn   <= '0;
      rdata        <= '0;
      cpu_ack      <= 1'b0;
      cpu_err      <= 1'b0;
      ld_ack       <= 1'b0;
      ld_err       <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      ld_ack  <= 1'b0;
      ld_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            last_grant   <= pick_ld;
            gnt_id       <= pick_ld;
            gnt_we       <= sel_we;
            gnt_in_range <= sel_in_range;
            ALU_MEM_Addr <= sel_addr;
            MEM_DataIn   <= sel_wdata;
            Mem_WrEn     <= sel_we && sel_in_range;
          end
        end
        ACCESS: begin
          Mem_WrEn <= 1'b0;
          // Out-of-range reads return zero; in-range writes leave rdata alone.
          if (!gnt_in_range) rdata <= '0;
          else if (!gnt_we)  rdata <= MEM_DataOut;
          if (gnt_id) begin
            ld_ack <= 1'b1;
            ld_err <= !gnt_in_range;
          end else begin
            cpu_ack <= 1'b1;
            cpu_err <= !gnt_in_range;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
